// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer.
// Holds the op codes, shift-register command codes, shift-amount mux
// selector codes, the FSM state enum and the op -> control decode helpers.
// Optional feature macro used by the sequencer: SHIFT_SEQ_LUI_EN.
package shift_pkg;

   // Shift operations carried on the op port
   localparam logic [2:0] OP_SLL  = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SRA  = 3'b010;
   localparam logic [2:0] OP_SLLV = 3'b011;
   localparam logic [2:0] OP_SRAV = 3'b100;
   localparam logic [2:0] OP_LUI  = 3'b101;

   // Shift-register commands
   localparam logic [2:0] CTRL_NOP   = 3'b000;
   localparam logic [2:0] CTRL_LOAD  = 3'b001;
   localparam logic [2:0] CTRL_LEFT  = 3'b010;
   localparam logic [2:0] CTRL_RIGHT = 3'b011;
   localparam logic [2:0] CTRL_ARITH = 3'b100;

   // Shift-amount mux selections
   localparam logic [1:0] SEL_SHAMT = 2'b00;
   localparam logic [1:0] SEL_C16   = 2'b01;
   localparam logic [1:0] SEL_REGB  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // Shift-amount source for a (valid) op; invalid ops fall back to shamt field
   function automatic logic [1:0] sel_for_op(input logic [2:0] o);
      logic [1:0] s;
      s = SEL_SHAMT;
      case (o)
         OP_SLLV, OP_SRAV: s = SEL_REGB;
         OP_LUI:           s = SEL_C16;
         default:          s = SEL_SHAMT;
      endcase
      return s;
   endfunction

   // Direction command driven while in SHIFT
   function automatic logic [2:0] dir_for_op(input logic [2:0] o);
      logic [2:0] d;
      d = CTRL_LEFT;
      case (o)
         OP_SRL:           d = CTRL_RIGHT;
         OP_SRA, OP_SRAV:  d = CTRL_ARITH;
         default:          d = CTRL_LEFT;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_wait_cnt.sv
// Down-counter that times the SHIFT state.
// Ports:
//   clk      - clock
//   reset    - synchronous active-low reset (count -> 0)
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one (ignored at zero)
//   zero     - count is zero
module shift_wait_cnt
   import shift_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Control sequencer for a multi-cycle shifter.
// Walks IDLE -> LOAD -> SHIFT (SHIFT_WAIT cycles) -> WRITE, or IDLE -> ERR
// for an invalid op. All outputs are registered alongside the state.
// Optional feature: define SHIFT_SEQ_LUI_EN to accept LUI (op=101); without
// it LUI takes the error path.
// Parameters:
//   SHIFT_WAIT - cycles spent in SHIFT (1..7, anything else becomes 1)
// Ports:
//   clk        - clock
//   reset      - synchronous active-low reset
//   start      - operation request, looked at only in IDLE
//   op         - shift operation code
//   shamt_sel  - shift-amount mux select (held for the whole busy period)
//   shift_ctrl - shift-register command
//   busy       - high in every non-IDLE state
//   done       - one-cycle result-valid pulse
//   reg_wr     - register-file write enable (with done)
//   err        - one-cycle invalid-op pulse
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int SHIFT_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   output logic [1:0] shamt_sel,
   output logic [2:0] shift_ctrl,
   output logic       busy,
   output logic       done,
   output logic       reg_wr,
   output logic       err
);

   localparam int         WAIT_EFF  = ((SHIFT_WAIT < 1) || (SHIFT_WAIT > 7)) ? 1 : SHIFT_WAIT;
   // Counter runs WAIT_EFF-1 .. 0 across the SHIFT cycles
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_EFF - 1);

   state_t     state;
   logic [2:0] op_latched;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;

   function automatic logic op_valid(input logic [2:0] o);
      logic v;
      v = 1'b0;
      case (o)
         OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRAV: v = 1'b1;
`ifdef SHIFT_SEQ_LUI_EN
         OP_LUI:                                   v = 1'b1;
`endif
         default:                                  v = 1'b0;
      endcase
      return v;
   endfunction

   assign cnt_load = (state == ST_LOAD);
   assign cnt_dec  = (state == ST_SHIFT);

   shift_wait_cnt #(.W(3)) u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         op_latched <= OP_SLL;
         shamt_sel  <= SEL_SHAMT;
         shift_ctrl <= CTRL_NOP;
         busy       <= 1'b0;
         done       <= 1'b0;
         reg_wr     <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_latched <= op;
                  busy       <= 1'b1;
                  if (op_valid(op)) begin
                     state      <= ST_LOAD;
                     shift_ctrl <= CTRL_LOAD;
                     shamt_sel  <= sel_for_op(op);
                  end else begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               state      <= ST_SHIFT;
               shift_ctrl <= dir_for_op(op_latched);
            end
            ST_SHIFT: begin
               // Counter was loaded on entry; leave once it reaches zero
               if (cnt_zero) begin
                  state      <= ST_WRITE;
                  shift_ctrl <= CTRL_NOP;
                  done       <= 1'b1;
                  reg_wr     <= 1'b1;
               end
            end
            ST_WRITE: begin
               state     <= ST_IDLE;
               done      <= 1'b0;
               reg_wr    <= 1'b0;
               busy      <= 1'b0;
               shamt_sel <= SEL_SHAMT;
            end
            ST_ERR: begin
               state <= ST_IDLE;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               shamt_sel  <= SEL_SHAMT;
               shift_ctrl <= CTRL_NOP;
               busy       <= 1'b0;
               done       <= 1'b0;
               reg_wr     <= 1'b0;
               err        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: one instance with SHIFT_WAIT=1 and one
// with SHIFT_WAIT=4. Outputs are compared as the packed word
// {shamt_sel, shift_ctrl, busy, done, reg_wr, err} on the falling edge.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start1 = 1'b0, start4 = 1'b0;
   logic [2:0] op1 = 3'b000, op4 = 3'b000;
   logic [1:0] sel1, sel4;
   logic [2:0] ctrl1, ctrl4;
   logic       busy1, done1, wr1, err1;
   logic       busy4, done4, wr4, err4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.SHIFT_WAIT(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .op(op1),
      .shamt_sel(sel1), .shift_ctrl(ctrl1), .busy(busy1),
      .done(done1), .reg_wr(wr1), .err(err1)
   );

   shift_sequencer #(.SHIFT_WAIT(4)) u4 (
      .clk(clk), .reset(reset), .start(start4), .op(op4),
      .shamt_sel(sel4), .shift_ctrl(ctrl4), .busy(busy4),
      .done(done4), .reg_wr(wr4), .err(err4)
   );

   wire [8:0] obs1 = {sel1, ctrl1, busy1, done1, wr1, err1};
   wire [8:0] obs4 = {sel4, ctrl4, busy4, done4, wr4, err4};

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Expected words {sel,ctrl,busy,done,reg_wr,err}
   localparam logic [8:0] IDLE_W = 9'b00_000_0000;

   initial begin
      // Reset
      cyc(); cyc();
      chk("reset_u1", obs1, IDLE_W);
      chk("reset_u4", obs4, IDLE_W);
      reset = 1'b1;
      cyc();
      chk("idle_no_start", obs1, IDLE_W);

      // SLL, SHIFT_WAIT=1
      start1 = 1'b1; op1 = 3'b000;
      cyc(); start1 = 1'b0; op1 = 3'b111;   // op change while busy must not matter
      $display("txn sll: start");
      chk("sll_c1_load",  obs1, 9'b00_001_1000);
      cyc(); chk("sll_c2_shift", obs1, 9'b00_010_1000);
      cyc(); chk("sll_c3_write", obs1, 9'b00_000_1110);
      cyc(); chk("sll_c4_idle",  obs1, IDLE_W);

      // SRAV
      start1 = 1'b1; op1 = 3'b100;
      cyc(); start1 = 1'b0;
      $display("txn srav: start");
      chk("srav_c1_load",  obs1, 9'b11_001_1000);
      cyc(); chk("srav_c2_shift", obs1, 9'b11_100_1000);
      cyc(); chk("srav_c3_write", obs1, 9'b11_000_1110);
      cyc(); chk("srav_c4_idle",  obs1, IDLE_W);

      // LUI
      start1 = 1'b1; op1 = 3'b101;
      cyc(); start1 = 1'b0;
      $display("txn lui: start");
`ifdef SHIFT_SEQ_LUI_EN
      chk("lui_c1_load",  obs1, 9'b01_001_1000);
      cyc(); chk("lui_c2_shift", obs1, 9'b01_010_1000);
      cyc(); chk("lui_c3_write", obs1, 9'b01_000_1110);
      cyc(); chk("lui_c4_idle",  obs1, IDLE_W);
`else
      chk("lui_c1_err",  obs1, 9'b00_000_1001);
      cyc(); chk("lui_c2_idle", obs1, IDLE_W);
`endif

      // Invalid op 111
      start1 = 1'b1; op1 = 3'b111;
      cyc(); start1 = 1'b0;
      $display("txn op111: start");
      chk("inv_c1_err",  obs1, 9'b00_000_1001);
      cyc(); chk("inv_c2_idle", obs1, IDLE_W);

      // SRL, SHIFT_WAIT=4, second start mid-SHIFT ignored
      start4 = 1'b1; op4 = 3'b001;
      cyc(); start4 = 1'b0;
      $display("txn srl_w4: start");
      chk("srl4_c1_load", obs4, 9'b00_001_1000);
      cyc(); chk("srl4_c2_shift", obs4, 9'b00_011_1000);
      start4 = 1'b1; op4 = 3'b000;
      cyc(); chk("srl4_c3_shift", obs4, 9'b00_011_1000);
      start4 = 1'b0;
      cyc(); chk("srl4_c4_shift", obs4, 9'b00_011_1000);
      cyc(); chk("srl4_c5_shift", obs4, 9'b00_011_1000);
      cyc(); chk("srl4_c6_write", obs4, 9'b00_000_1110);
      cyc(); chk("srl4_c7_idle",  obs4, IDLE_W);
      cyc(); chk("srl4_c8_idle",  obs4, IDLE_W);

      // Start held from the WRITE cycle: ignored there, taken in next IDLE
      start1 = 1'b1; op1 = 3'b000;
      cyc(); start1 = 1'b0;
      $display("txn back_to_back: start");
      chk("b2b_c1_load", obs1, 9'b00_001_1000);
      cyc(); chk("b2b_c2_shift", obs1, 9'b00_010_1000);
      cyc(); chk("b2b_c3_write", obs1, 9'b00_000_1110);
      start1 = 1'b1; op1 = 3'b001;
      cyc(); chk("b2b_c4_idle", obs1, IDLE_W);
      cyc(); start1 = 1'b0;
      chk("b2b_c5_load",  obs1, 9'b00_001_1000);
      cyc(); chk("b2b_c6_shift", obs1, 9'b00_011_1000);
      cyc(); chk("b2b_c7_write", obs1, 9'b00_000_1110);
      cyc(); chk("b2b_c8_idle",  obs1, IDLE_W);

      // Reset during SHIFT aborts with no done
      start4 = 1'b1; op4 = 3'b010;
      cyc(); start4 = 1'b0;
      $display("txn sra_w4_abort: start");
      chk("abort_c1_load",  obs4, 9'b00_001_1000);
      cyc(); chk("abort_c2_shift", obs4, 9'b00_100_1000);
      reset = 1'b0;
      cyc(); chk("abort_c3_idle", obs4, IDLE_W);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(); chk("abort_no_done", obs4, IDLE_W);
      end

      // Fresh op after abort still runs the full SHIFT_WAIT
      start4 = 1'b1; op4 = 3'b011;
      cyc(); start4 = 1'b0;
      $display("txn sllv_w4: start");
      chk("sllv4_c1_load", obs4, 9'b11_001_1000);
      for (int i = 0; i < 4; i++) begin
         cyc(); chk("sllv4_shift", obs4, 9'b11_010_1000);
      end
      cyc(); chk("sllv4_write", obs4, 9'b11_000_1110);
      cyc(); chk("sllv4_idle",  obs4, IDLE_W);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter SHIFT_WAIT, default 1: cycles held in SHIFT state (1..7) for multi-cycle shifter settling.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port start, input, 1: main-control request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 3: shift operation (SLL=000, SRL=001, SRA=010, SLLV=011, SRAV=100, LUI=101; others invalid).
REQ-006 SHALL have port shamt_sel, output, 2: shift-amount mux selector (00 shamt field, 01 constant 16, 11 register B).
REQ-007 SHALL have port shift_ctrl, output, 3: shift-register command (000 nop, 001 load, 010 left, 011 right logical, 100 right arith).
REQ-008 SHALL have port busy, output, 1: high in every non-IDLE state.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the result is valid.
REQ-010 SHALL have port reg_wr, output, 1: register-file write enable, asserted with done.
REQ-011 SHALL have port err, output, 1: one-cycle pulse on invalid op.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SHIFT, WRITE, ERR.
REQ-013 IDLE with start=1 SHALL latch op and go to LOAD if valid, ERR if invalid; start=0 SHALL stay IDLE.
REQ-014 LOAD SHALL drive shift_ctrl=001 for exactly one cycle, then go to SHIFT.
REQ-015 shamt_sel SHALL be registered from the latched op for the whole busy period: SLL/SRL/SRA→00, SLLV/SRAV→11, LUI→01; 00 in IDLE.
REQ-016 SHIFT SHALL drive the latched direction (SLL/SLLV/LUI→010, SRL→011, SRA/SRAV→100) for exactly SHIFT_WAIT cycles via a down-counter, then go to WRITE.
REQ-017 WRITE SHALL assert done=1 and reg_wr=1 for one cycle with shift_ctrl=000, then return to IDLE.
REQ-018 ERR SHALL assert err=1 for one cycle with reg_wr=0, then return to IDLE.
REQ-019 Latency start→done SHALL be 2+SHIFT_WAIT cycles (SHIFT_WAIT=1: done in the third cycle after start is sampled).
REQ-020 start while busy=1 SHALL be ignored, and op changes while busy SHALL NOT affect the operation in progress.
REQ-021 start asserted in the WRITE/ERR cycle SHALL be ignored; a new start is accepted the following IDLE cycle.
REQ-022 SHIFT_WAIT outside 1..7 SHALL be clamped to 1 at elaboration.

Reset
REQ-023 reset=0 SHALL, on the next rising edge, force IDLE, shamt_sel=00, shift_ctrl=000, busy=0, done=0, reg_wr=0, err=0, and counter=0.
REQ-024 reset during any state SHALL abort the operation with no done or reg_wr pulse.

Configuration
REQ-025 Macro SHIFT_SEQ_LUI_EN defined SHALL enable LUI (op=101) per REQ-015/016.
REQ-026 Without SHIFT_SEQ_LUI_EN, op=101 SHALL be invalid (ERR path), and shamt_sel=01 SHALL never be driven.

Structure
REQ-027 op codes, shift_ctrl codes, shamt_sel codes and the state enum SHALL live in shared package shift_pkg.
REQ-028 The SHIFT_WAIT down-counter SHALL be a sub-module shift_wait_cnt (load, decrement, zero flag); everything else stays in one module.

Verification
REQ-029 SHIFT_WAIT=1, op=SLL, 1-cycle start → shamt_sel=00; shift_ctrl 001,010,000 on consecutive cycles; done=reg_wr=1 in cycle 3.
REQ-030 op=SRAV → shamt_sel=11 for the whole busy period; shift_ctrl=100 in SHIFT; done after 3 cycles.
REQ-031 LUI with SHIFT_SEQ_LUI_EN → shamt_sel=01, shift_ctrl=010; without the macro → err pulse in cycle 1, no reg_wr.
REQ-032 SHIFT_WAIT=4, op=SRL, and start re-pulsed with op=SLL mid-SHIFT → shift_ctrl=011 held 4 cycles, done at cycle 6, second start ignored.
REQ-033 reset=0 asserted during SHIFT → next cycle IDLE, all outputs 0, no done; op=111 → err=1 one cycle, busy for one cycle only.
